// File: rtl/gpu_pkg.sv
// Shared sizes, memory map and FSM state type for the 2x2 matrix-multiply GPU.
// Address helpers keep the row-major operand layout and the C layout in one place.
package gpu_pkg;

    localparam int MEM_DEPTH = 16;
    localparam int A_BASE    = 0;
    localparam int B_BASE    = 4;
    localparam int C_BASE    = 8;
    localparam int N_ELEM    = 4;
    localparam int N_RPORT   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // A[row][col] lives at A_BASE + 2*row + col.
    function automatic logic [3:0] a_addr(input logic row, input logic col);
        return 4'(A_BASE) + {2'b00, row, col};
    endfunction

    // B[row][col] lives at B_BASE + 2*row + col.
    function automatic logic [3:0] b_addr(input logic row, input logic col);
        return 4'(B_BASE) + {2'b00, row, col};
    endfunction

    // Low byte of C element e (0=C00 .. 3=C11); the high byte follows it.
    function automatic logic [3:0] c_lo_addr(input logic [1:0] elem);
        return 4'(C_BASE) + {1'b0, elem, 1'b0};
    endfunction

endpackage

// File: rtl/gpu_memory.sv
// 16x8 unified memory: four async byte read ports, one 16-bit element write port
// into the C region, async clear of the C region, and a continuous flat view.
module gpu_memory
    import gpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  raddr_i [0:N_RPORT-1],
    output logic [7:0]  rdata_o [0:N_RPORT-1],
    input  logic        we_i,
    input  logic [1:0]  welem_i,
    input  logic [15:0] wdata_i,
    output logic [7:0]  mem_o   [0:MEM_DEPTH-1]
);

    logic [7:0] mem [0:MEM_DEPTH-1];

    logic [3:0] wlo_addr;
    logic [3:0] whi_addr;

    assign wlo_addr = c_lo_addr(welem_i);
    assign whi_addr = wlo_addr | 4'd1;

    // Bytes 0..7 are never touched here: they belong to whoever preloads operands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = C_BASE; k < MEM_DEPTH; k++) begin
                mem[k] <= 8'd0;
            end
        end else if (we_i) begin
            mem[wlo_addr] <= wdata_i[7:0];
            mem[whi_addr] <= wdata_i[15:8];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_RPORT; gi++) begin : g_rport
            assign rdata_o[gi] = mem[raddr_i[gi]];
        end
        for (gi = 0; gi < MEM_DEPTH; gi++) begin : g_view
            assign mem_o[gi] = mem[gi];
        end
    endgenerate

endmodule

// File: rtl/gpu_top.sv
// Self-starting 2x2 unsigned 8-bit matrix multiply C = A x B over a shared 16-byte memory.
// One C element is computed and written per cycle in CALC; results hold in DONE until reset.
module gpu_top
    import gpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] mem_out [0:MEM_DEPTH-1]
);

    state_e      state_q;
    state_e      state_d;
    logic [1:0]  idx_q;
    logic [1:0]  idx_d;

    logic        we;
    logic [3:0]  raddr [0:N_RPORT-1];
    logic [7:0]  rdata [0:N_RPORT-1];
    logic [15:0] prod0;
    logic [15:0] prod1;
    logic [15:0] mac_sum;
    logic        row;
    logic        col;

    assign row = idx_q[1];
    assign col = idx_q[0];

    // Operand ports: Ai0, Ai1, B0j, B1j for the element currently indexed.
    assign raddr[0] = a_addr(row, 1'b0);
    assign raddr[1] = a_addr(row, 1'b1);
    assign raddr[2] = b_addr(1'b0, col);
    assign raddr[3] = b_addr(1'b1, col);

    assign prod0   = {8'd0, rdata[0]} * {8'd0, rdata[2]};
    assign prod1   = {8'd0, rdata[1]} * {8'd0, rdata[3]};
    assign mac_sum = prod0 + prod1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we      = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = CALC;
                idx_d   = 2'd0;
            end
            CALC: begin
                we = 1'b1;
                if (idx_q == 2'(N_ELEM - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    gpu_memory mem (
        .clk_i   (clk),
        .rst_i   (reset),
        .raddr_i (raddr),
        .rdata_o (rdata),
        .we_i    (we),
        .welem_i (idx_q),
        .wdata_i (mac_sum),
        .mem_o   (mem_out)
    );

endmodule

// File: tb/tb_gpu_top.sv
// Randomized self-checking bench for gpu_top against a plain-arithmetic matrix-product model.
module tb_gpu_top;

    logic       clk;
    logic       reset;
    logic [7:0] mem_out [0:15];

    int checks;
    int errors;

    logic [7:0] a_m [0:3];
    logic [7:0] b_m [0:3];

    gpu_top gpu (
        .clk     (clk),
        .reset   (reset),
        .mem_out (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cij = Ai0*B0j + Ai1*B1j modulo 2^16.
    function automatic int model_c(input int e);
        int i;
        int j;
        i = e / 2;
        j = e % 2;
        return (int'(a_m[2*i]) * int'(b_m[j]) + int'(a_m[2*i+1]) * int'(b_m[2+j])) % 65536;
    endfunction

    task automatic preload();
        for (int k = 0; k < 4; k++) begin
            gpu.mem.mem[k]   = a_m[k];
            gpu.mem.mem[4+k] = b_m[k];
        end
    endtask

    task automatic check_c_zero(input string tag);
        for (int k = 8; k < 16; k++) begin
            check($sformatf("%s byte%0d", tag, k), int'(mem_out[k]), 0);
        end
    endtask

    task automatic check_results(input string tag);
        for (int e = 0; e < 4; e++) begin
            check($sformatf("%s C%0d", tag, e),
                  int'({mem_out[9+2*e], mem_out[8+2*e]}), model_c(e));
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s A%0d", tag, k), int'(mem_out[k]), int'(a_m[k]));
            check($sformatf("%s B%0d", tag, k), int'(mem_out[4+k]), int'(b_m[k]));
        end
    endtask

    task automatic wait_edges(input int n);
        for (int c = 0; c < n; c++) @(posedge clk);
        #1;
    endtask

    // Reset, preload, release on a falling edge, then check at the 6-edge latency and later.
    task automatic run_case(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        preload();
        @(negedge clk);
        check_c_zero({tag, " rst"});
        reset = 1'b0;
        wait_edges(6);
        check_results({tag, " lat6"});
        wait_edges(9);
        check_results({tag, " hold"});
        $display("txn %s: A=%0d,%0d,%0d,%0d B=%0d,%0d,%0d,%0d C=%0d,%0d,%0d,%0d", tag,
                 a_m[0], a_m[1], a_m[2], a_m[3], b_m[0], b_m[1], b_m[2], b_m[3],
                 model_c(0), model_c(1), model_c(2), model_c(3));
    endtask

    task automatic set_ab(input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < 4; k++) begin
            a_m[k] = a[31-8*k -: 8];
            b_m[k] = b[31-8*k -: 8];
        end
    endtask

    initial begin
        int k;
        logic [7:0] v;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        #1;
        check_c_zero("por");

        set_ab(32'h01010101, 32'h01010101);
        run_case("ones");

        set_ab(32'h00000000, 32'h00000000);
        run_case("zeros");

        set_ab(32'h01020304, 32'h05060708);
        run_case("seq");

        set_ab(32'hFFFFFFFF, 32'hFFFFFFFF);
        run_case("max");

        // Abort mid-CALC: C00 lands on the second edge, then reset wipes the C region.
        set_ab(32'h01000001, 32'h09080706);
        @(negedge clk);
        reset = 1'b1;
        #1;
        preload();
        @(negedge clk);
        reset = 1'b0;
        wait_edges(2);
        check("abort C00 before rst", int'({mem_out[9], mem_out[8]}), model_c(0));
        reset = 1'b1;
        #1;
        check_c_zero("abort rst");
        @(negedge clk);
        reset = 1'b0;
        wait_edges(15);
        check_results("abort final");
        $display("txn abort: C=%0d,%0d,%0d,%0d", model_c(0), model_c(1), model_c(2), model_c(3));

        // The flat view follows direct writes to the operand bytes while reset is held.
        @(negedge clk);
        reset = 1'b1;
        for (int t = 0; t < 6; t++) begin
            k = int'($urandom_range(0, 7));
            v = 8'($urandom);
            gpu.mem.mem[k] = v;
            #1;
            check($sformatf("view byte%0d", k), int'(mem_out[k]), int'(v));
            $display("txn view: byte%0d <= %0d", k, v);
        end

        for (int r = 0; r < 8; r++) begin
            set_ab($urandom, $urandom);
            run_case($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
